// File: rtl/train_actuator_sequencer.sv
// Decodes the controller's present_state into motor/switch commands, inserting a
// timed stop/throw/resume sequence for switch throws and reversals while moving.
module train_actuator_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned THROW_CYCLES  = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] present_state,
  output logic [1:0] motor_speed,
  output logic       motor_dir,
  output logic       switch_pos,
  output logic       switch_pulse,
  output logic       signal_red,
  output logic       signal_green,
  output logic       busy,
  output logic       ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STOP,
    S_THROW,
    S_APPLY,
    S_ACK
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] THROW_LAST  = CNT_W'(THROW_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       cur_state, cur_state_nxt;
  logic [3:0]       tgt, tgt_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [1:0]       speed_nxt;
  logic             dir_nxt;
  logic             pos_nxt;
  logic             pulse_nxt;
  logic             ack_nxt;
  logic             need_stop;

  assign need_stop = (present_state[3] != switch_pos) ||
                     ((present_state[2] != motor_dir) && (motor_speed != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur_state    <= '0;
      tgt          <= '0;
      timer        <= '0;
      motor_speed  <= '0;
      motor_dir    <= 1'b0;
      switch_pos   <= 1'b0;
      switch_pulse <= 1'b0;
      signal_red   <= 1'b1;
      signal_green <= 1'b0;
      busy         <= 1'b0;
      ack          <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_state    <= cur_state_nxt;
      tgt          <= tgt_nxt;
      timer        <= timer_nxt;
      motor_speed  <= speed_nxt;
      motor_dir    <= dir_nxt;
      switch_pos   <= pos_nxt;
      switch_pulse <= pulse_nxt;
      signal_red   <= (speed_nxt == '0);
      signal_green <= (speed_nxt != '0);
      busy         <= (state_nxt != S_IDLE);
      ack          <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_state_nxt = cur_state;
    tgt_nxt       = tgt;
    timer_nxt     = timer;
    speed_nxt     = motor_speed;
    dir_nxt       = motor_dir;
    pos_nxt       = switch_pos;
    pulse_nxt     = switch_pulse;
    ack_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (present_state != cur_state) begin
          tgt_nxt       = present_state;
          cur_state_nxt = present_state;
          if (need_stop) begin
            state_nxt = S_STOP;
            speed_nxt = '0;
            timer_nxt = SETTLE_LAST;
          end else begin
            state_nxt = S_APPLY;
          end
        end
      end
      S_STOP: begin
        if (timer == '0) begin
          if (tgt[3] != switch_pos) begin
            state_nxt = S_THROW;
            pos_nxt   = tgt[3];
            pulse_nxt = 1'b1;
            timer_nxt = THROW_LAST;
          end else begin
            state_nxt = S_APPLY;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_THROW: begin
        if (timer == '0) begin
          pulse_nxt = 1'b0;
          state_nxt = S_APPLY;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_APPLY: begin
        speed_nxt = tgt[1:0];
        dir_nxt   = tgt[2];
        state_nxt = S_ACK;
      end
      // ack is registered on leaving ACK, so the strobe shows the cycle after ACK
      // and drops on the edge where IDLE next compares present_state.
      S_ACK: begin
        ack_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_train_actuator_sequencer.sv
// Directed bench for train_actuator_sequencer with hand-computed expectations.
module tb_train_actuator_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] present_state;
  logic [1:0] motor_speed;
  logic       motor_dir;
  logic       switch_pos;
  logic       switch_pulse;
  logic       signal_red;
  logic       signal_green;
  logic       busy;
  logic       ack;

  int tests;
  int errors;

  int pulse_cnt, first_pulse, ack_at, ack_cnt, overlap, zero_pre, busy_cnt;
  int busy_k0, busy_last, spd_at_ack, dir_at_ack, green_at_ack;

  train_actuator_sequencer #(
    .SETTLE_CYCLES(8),
    .THROW_CYCLES (16),
    .CNT_W        (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .present_state(present_state),
    .motor_speed  (motor_speed),
    .motor_dir    (motor_dir),
    .switch_pos   (switch_pos),
    .switch_pulse (switch_pulse),
    .signal_red   (signal_red),
    .signal_green (signal_green),
    .busy         (busy),
    .ack          (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample index k counts edges after the call; k=0 is the edge that samples a new request.
  task automatic run_seq(input int n);
    pulse_cnt = 0; first_pulse = -1; ack_at = -1; ack_cnt = 0; overlap = 0;
    zero_pre = 0; busy_cnt = 0; busy_k0 = 0; busy_last = 0;
    spd_at_ack = -1; dir_at_ack = -1; green_at_ack = -1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (switch_pulse) begin
        pulse_cnt++;
        if (first_pulse < 0) first_pulse = k;
      end
      if (ack) begin
        ack_cnt++;
        ack_at       = k;
        spd_at_ack   = int'(motor_speed);
        dir_at_ack   = int'(motor_dir);
        green_at_ack = int'(signal_green);
      end
      if (ack && switch_pulse) overlap++;
      if (first_pulse < 0 && motor_speed == 2'd0) zero_pre++;
      if (busy) busy_cnt++;
      if (k == 0) busy_k0 = int'(busy);
      busy_last = int'(busy);
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst_n  = 1'b0;
    present_state = 4'h0;
    #12;
    check("rst_speed", motor_speed, 0);
    check("rst_red", signal_red, 1);
    check("rst_green", signal_green, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_pos", switch_pos, 0);
    rst_n = 1'b1;

    // Idle with unchanged present_state
    run_seq(6);
    check("idle_acks", ack_cnt, 0);
    check("idle_busy", busy_cnt, 0);

    // Fast path 0x0 -> 0x3
    present_state = 4'h3;
    run_seq(4);
    check("fast_busy_k0", busy_k0, 1);
    check("fast_ack_at", ack_at, 2);
    check("fast_ack_cnt", ack_cnt, 1);
    check("fast_speed", spd_at_ack, 3);
    check("fast_green", green_at_ack, 1);
    check("fast_pulse", pulse_cnt, 0);
    check("fast_busy_end", busy_last, 0);

    // Switch change 0x3 -> 0xB
    present_state = 4'hB;
    run_seq(28);
    check("sw_zero_pre", zero_pre, 8);
    check("sw_first_pulse", first_pulse, 8);
    check("sw_pulse_cnt", pulse_cnt, 16);
    check("sw_ack_at", ack_at, 26);
    check("sw_ack_cnt", ack_cnt, 1);
    check("sw_speed", spd_at_ack, 3);
    check("sw_overlap", overlap, 0);
    check("sw_pos", switch_pos, 1);

    // Back to 0x3 (throws switch back)
    present_state = 4'h3;
    run_seq(28);
    check("swback_ack_at", ack_at, 26);
    check("swback_pos", switch_pos, 0);

    // Reverse while moving 0x3 -> 0x7
    present_state = 4'h7;
    run_seq(12);
    check("rev_pulse", pulse_cnt, 0);
    check("rev_zero", zero_pre, 9);
    check("rev_ack_at", ack_at, 10);
    check("rev_speed", spd_at_ack, 3);
    check("rev_dir", dir_at_ack, 1);

    // Stop with reversal 0x7 -> 0x0 (moving, dir differs)
    present_state = 4'h0;
    run_seq(12);
    check("stop_ack_at", ack_at, 10);
    check("stop_speed", spd_at_ack, 0);
    check("stop_red", signal_red, 1);

    // Dir change while stopped 0x0 -> 0x4 takes fast path
    present_state = 4'h4;
    run_seq(4);
    check("dir0_ack_at", ack_at, 2);
    check("dir0_dir", dir_at_ack, 1);

    // Changes while busy are dropped; only the final value is applied
    present_state = 4'hB;
    ack_at = -1; ack_cnt = 0;
    for (int k = 0; k < 27; k++) begin
      tick();
      if (k == 2) present_state = 4'hC;
      if (k == 5) present_state = 4'hD;
      if (ack) begin
        ack_cnt++;
        ack_at     = k;
        spd_at_ack = int'(motor_speed);
        dir_at_ack = int'(motor_dir);
      end
    end
    check("busyB_ack_at", ack_at, 26);
    check("busyB_speed", spd_at_ack, 3);
    check("busyB_dir", dir_at_ack, 0);
    run_seq(14);
    check("busyD_ack_cnt", ack_cnt, 1);
    check("busyD_ack_at", ack_at, 10);
    check("busyD_pulse", pulse_cnt, 0);
    check("busyD_speed", spd_at_ack, 1);
    check("busyD_dir", dir_at_ack, 1);
    check("busyD_idle", busy_last, 0);

    // Reset during the 5th pulse cycle of a throw
    present_state = 4'h5;
    for (int k = 0; k < 13; k++) tick();
    check("mid_pulse", switch_pulse, 1);
    rst_n = 1'b0;
    present_state = 4'h0;
    #1;
    check("arst_pulse", switch_pulse, 0);
    check("arst_pos", switch_pos, 0);
    check("arst_speed", motor_speed, 0);
    check("arst_ack", ack, 0);
    check("arst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    run_seq(4);
    check("post_rst_acks", ack_cnt, 0);
    check("post_rst_busy", busy_cnt, 0);
    present_state = 4'h1;
    run_seq(4);
    check("post_rst_ack_at", ack_at, 2);
    check("post_rst_speed", spd_at_ack, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
